// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small transmit FIFO.
// Ports: clk, rst (async, active-high), tx_data/tx_valid/tx_ready push side,
//        tx (serial line, idle high), tx_busy, fifo_count.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic [4:0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [4:0]    DEPTH     = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic          r_tx;
  logic          w_tx_n;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [4:0]    r_count;
  // Cleared by reset, set on the first clock after it: keeps
  // tx_ready low while rst is held without a path from rst.
  logic          r_live;

  logic          w_push;
  logic          w_pop;
  logic          w_tick;
  logic          w_has;
  logic [7:0]    w_head;

  assign w_has    = (r_count != 5'd0);
  assign w_head   = r_mem[r_rptr];
  assign w_tick   = (r_baud == BAUD_LAST);

  assign tx_ready = r_live && (r_count < DEPTH);
  assign w_push   = tx_valid && tx_ready;

  assign tx         = r_tx;
  assign fifo_count = r_count;
  assign tx_busy    = (r_state != S_IDLE) || w_has;

  // Next-state logic. A pop is only ever requested when the
  // FIFO holds data, so the head read is always valid.
  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_has) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_baud_n  = '0;
          w_bit_n   = 3'd0;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_baud_n  = '0;
          w_bit_n   = 3'd0;
          w_state_n = S_DATA;
        end else begin
          w_baud_n = r_baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_n   = 3'd0;
            w_state_n = S_STOP;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end else begin
          w_baud_n = r_baud + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_baud_n = '0;
          w_bit_n  = 3'd0;
          // Back-to-back frames: chain straight into START.
          if (w_has) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_state_n = S_START;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_baud_n = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_baud_n  = '0;
        w_bit_n   = 3'd0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Line level is a function of the state being entered, so the
  // registered tx changes on the same edge as the state.
  always_comb begin
    w_tx_n = 1'b1;
    unique case (1'b1)
      (w_state_n == S_START): w_tx_n = 1'b0;
      (w_state_n == S_DATA):  w_tx_n = w_shift_n[0];
      default:                w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 5'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [4:0] fifo_count;

  int checks;
  int errors;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k cycles into a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int s;
    s = k / CPB;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL rst_tx: got %b want 1", tx);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", tx_busy);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready: got %b want 0", tx_ready);
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++; $display("FAIL rst_count: got %0d want 0", fifo_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready: got %b want 1", tx_ready);
    end
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: got tx=%b busy=%b want 1/0", tx, tx_busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    b = 8'h55;
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx !== 1'b1 || fifo_count !== 5'd1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: got tx=%b cnt=%0d busy=%b want 1/1/1",
               tx, fifo_count, tx_busy);
    end
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(b, k)) begin
        errors++;
        $display("FAIL single_tx[%0d]: got %b want %b", k, tx, exp_bit(b, k));
      end
      if (k == 0) begin
        checks++;
        if (fifo_count !== 5'd0) begin
          errors++; $display("FAIL single_pop: got %0d want 0", fifo_count);
        end
      end
      if (k == FL - 1) begin
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++; $display("FAIL single_busy_stop: got %b want 1", tx_busy);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end: got busy=%b tx=%b want 0/1", tx_busy, tx);
    end
  endtask

  task automatic test_zero();
    int lows;
    int highs;
    lows = 0; highs = 0;
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < 9 * CPB; k++) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    for (int k = 0; k < 2 * CPB; k++) begin
      @(negedge clk);
      if (tx === 1'b1) highs++;
    end
    checks++;
    if (lows != 9 * CPB) begin
      errors++; $display("FAIL zero_low: got %0d want %0d", lows, 9 * CPB);
    end
    checks++;
    if (highs != 2 * CPB) begin
      errors++; $display("FAIL zero_high: got %0d want %0d", highs, 2 * CPB);
    end
  endtask

  task automatic test_burst();
    logic [7:0] bv [6];
    bv = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h7E};
    for (int n = 0; n <= 5 * FL + 2; n++) begin
      @(negedge clk);
      if (n >= 2 && n < 5 * FL + 2) begin
        checks++;
        if (tx !== exp_bit(bv[(n-2)/FL], (n-2) % FL)) begin
          errors++;
          $display("FAIL burst_tx[%0d]: got %b want %b", n - 2, tx,
                   exp_bit(bv[(n-2)/FL], (n-2) % FL));
        end
      end
      if (n < 6) begin
        checks++;
        if (tx_ready !== (n < 5)) begin
          errors++;
          $display("FAIL burst_ready[%0d]: got %b want %b", n, tx_ready, n < 5);
        end
        tx_valid = 1'b1; tx_data = bv[n];
      end else begin
        tx_valid = 1'b0;
      end
      if (n == 5 || n == 6) begin
        checks++;
        if (fifo_count !== 5'd4) begin
          errors++; $display("FAIL burst_full[%0d]: got %0d want 4", n, fifo_count);
        end
      end
      if (n == 5 * FL + 2) begin
        checks++;
        if (tx_busy !== 1'b0 || fifo_count !== 5'd0) begin
          errors++;
          $display("FAIL burst_end: got busy=%b cnt=%0d want 0/0", tx_busy, fifo_count);
        end
      end
    end
  endtask

  task automatic test_push_at_stop();
    logic [7:0] bv [3];
    bv = '{8'hC3, 8'h5A, 8'h96};
    for (int n = 0; n <= 3 * FL + 2; n++) begin
      @(negedge clk);
      if (n >= 2 && n < 3 * FL + 2) begin
        checks++;
        if (tx !== exp_bit(bv[(n-2)/FL], (n-2) % FL)) begin
          errors++;
          $display("FAIL stop_tx[%0d]: got %b want %b", n - 2, tx,
                   exp_bit(bv[(n-2)/FL], (n-2) % FL));
        end
      end
      if (n == 41 || n == 42 || n == 81) begin
        checks++;
        if (fifo_count !== 5'd1) begin
          errors++; $display("FAIL stop_count[%0d]: got %0d want 1", n, fifo_count);
        end
      end
      if (n == 82) begin
        checks++;
        if (fifo_count !== 5'd0) begin
          errors++; $display("FAIL stop_count[82]: got %0d want 0", fifo_count);
        end
      end
      if (n == 3 * FL + 2) begin
        checks++;
        if (tx_busy !== 1'b0) begin
          errors++; $display("FAIL stop_end_busy: got %b want 0", tx_busy);
        end
      end
      tx_valid = (n == 0 || n == 1 || n == 41);
      tx_data  = (n == 0) ? bv[0] : (n == 1) ? bv[1] : bv[2];
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [7:0] bv [3];
    bv = '{8'h00, 8'hFF, 8'h81};
    for (int n = 0; n <= 19; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        checks++;
        if (tx !== exp_bit(bv[0], n - 2)) begin
          errors++;
          $display("FAIL rmid_tx[%0d]: got %b want %b", n - 2, tx, exp_bit(bv[0], n - 2));
        end
      end
      if (n == 3) begin
        checks++;
        if (fifo_count !== 5'd2) begin
          errors++; $display("FAIL rmid_queued: got %0d want 2", fifo_count);
        end
      end
      tx_valid = (n < 3);
      if (n < 3) tx_data = bv[n];
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL rmid_abort: got tx=%b cnt=%0d want 1/0", tx, fifo_count);
    end
    checks++;
    if (tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_flags: got busy=%b rdy=%b want 0/0", tx_busy, tx_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 5'd0) begin
        errors++;
        $display("FAIL rmid_quiet[%0d]: got tx=%b busy=%b cnt=%0d want 1/0/0",
                 i, tx, tx_busy, fifo_count);
      end
      if (i == 0) begin
        checks++;
        if (tx_ready !== 1'b1) begin
          errors++; $display("FAIL rmid_ready: got %b want 1", tx_ready);
        end
      end
    end
  endtask

  task automatic test_data_change();
    logic [7:0] b;
    b = 8'h3C;
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      tx_data = 8'(k * 37 + 11);
      @(negedge clk);
      checks++;
      if (tx !== exp_bit(b, k)) begin
        errors++;
        $display("FAIL hold_tx[%0d]: got %b want %b", k, tx, exp_bit(b, k));
      end
    end
    @(negedge clk);
  endtask

  // Receiver-style decode: find the start edge, sample mid-bit.
  task automatic test_loopback();
    logic [7:0] got;
    int  wait_n;
    logic start_b;
    logic stop_b;
    got = 8'h00; wait_n = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    while (tx !== 1'b0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL loop_start: got %b want 0 within 10 cycles", tx);
    end
    repeat (CPB / 2 - 1) @(negedge clk);
    start_b = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      got[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    stop_b = tx;
    checks++;
    if (start_b !== 1'b0 || stop_b !== 1'b1) begin
      errors++;
      $display("FAIL loop_frame: got start=%b stop=%b want 0/1", start_b, stop_b);
    end
    checks++;
    if (got !== 8'hA5) begin
      errors++; $display("FAIL loop_data: got %02h want a5", got);
    end
    repeat (CPB) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL loop_idle: got %b want 0", tx_busy);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single();
    test_zero();
    test_burst();
    test_push_at_stop();
    test_rst_mid();
    test_data_change();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10416, meaning clk cycles per serial bit (100 MHz clk, 9600 baud); legal range 2..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL provide port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port tx_data  input  8  byte to transmit; sampled only on an accepting edge.
REQ-006 SHALL provide port tx_valid  input  1  tx_data is offered this cycle.
REQ-007 SHALL provide port tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL provide port tx  output  1  serial line, idle high, registered.
REQ-009 SHALL provide port tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL provide port fifo_count  output  5  bytes currently held in FIFO, 0..FIFO_DEPTH.

Function
REQ-011 SHALL accept a byte on each rising edge where tx_valid=1 and tx_ready=1; tx_valid with tx_ready=0 SHALL be ignored, with no side effects.
REQ-012 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), derived from registered state only, with no combinational path from tx_valid.
REQ-013 FIFO SHALL be first-in first-out with wrap-around read/write pointers; a push and a pop in the same cycle SHALL leave fifo_count unchanged and lose no data.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; if fifo_count>0, SHALL pop the head byte into a shift register and enter START on the same edge.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-017 DATA: tx=shift[0] (LSB first), each bit held exactly CLKS_PER_BIT cycles; after bit 7, enter STOP.
REQ-018 STOP: tx=1 for exactly CLKS_PER_BIT cycles; then, if fifo_count>0, SHALL pop and enter START directly (no idle gap), else enter IDLE.
REQ-019 Each frame SHALL occupy exactly 10*CLKS_PER_BIT cycles; 8N1, no parity.
REQ-020 Latency: with the FSM in IDLE and the FIFO empty, tx SHALL go low on the first rising edge after the accepting edge.
REQ-021 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and reload to 0 at each bit boundary with no cumulative drift.
REQ-022 SHALL drive tx_busy = (state != IDLE) || (fifo_count != 0).
REQ-023 Changes on tx_data or tx_valid during a frame SHALL NOT affect the byte being shifted.
REQ-024 A pop on an empty FIFO SHALL never occur; a push on a full FIFO SHALL never occur.

Reset
REQ-025 While rst=1, SHALL hold: tx=1, state=IDLE, fifo_count=0, pointers=0, baud counter=0, bit index=0, tx_busy=0, tx_ready=0.
REQ-026 Assertion of rst mid-frame SHALL force tx=1 immediately (asynchronous), abort the frame, and flush the FIFO.
REQ-027 On the first edge after rst deasserts, tx_ready SHALL be 1; no frame SHALL start until a new byte is accepted.

Verification
REQ-028 CLKS_PER_BIT=10416: push 0x55 once -> tx = 0,1,0,1,0,1,0,1,0,1, each level held 104160 ns; tx_busy falls after 1041600 ns.
REQ-029 Loopback of tx into uart_rx (rx input), push 0xA5 -> rx_done pulses once with rx_data=0xA5.
REQ-030 CLKS_PER_BIT=4: hold tx_valid=1 for 6 consecutive cycles with bytes 0x00,0xFF,0xA5,0x3C,0x81,0x7E -> exactly the first 5 are accepted and tx_ready=0 from cycle 5; 5 contiguous frames, 200 cycles total, bytes in order.
REQ-031 CLKS_PER_BIT=4: push a byte on the same cycle that STOP completes and pops -> fifo_count unchanged, both bytes transmitted, no gap between frames.
REQ-032 CLKS_PER_BIT=4: assert rst during DATA bit 3 with 2 bytes queued -> tx=1 within the same cycle, fifo_count=0; after release, tx stays 1 and tx_busy=0 for 100 cycles.
REQ-033 Push 0x00 -> the low period is exactly 9*CLKS_PER_BIT cycles (start plus 8 zero bits), followed by a 1*CLKS_PER_BIT high stop bit.
